// File: rtl/data_sram_ctrl_if.sv
// Split address/data handshake between the MEM-stage sequencer and the data SRAM.
interface data_sram_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_ctrl.sv
// Data SRAM sequencer for the MEM stage: one load/store per request over a
// variable-latency split address/data handshake, stalling the pipe until done.
// Optional watchdog abort: define DATA_SRAM_TIMEOUT_EN (adds TIMEOUT_CYCLES and
// ERR_RDATA parameters); without it a stalled SRAM hangs the pipeline.
module data_sram_ctrl
`ifdef DATA_SRAM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_req_i,
  input  logic [3:0]         ex_wen_i,
  input  logic [31:0]        ex_addr_i,
  input  logic [31:0]        ex_wdata_i,
  input  logic               pipe_stall_i,
  data_sram_if.master        sram,
  output logic [31:0]        mem_rdata_o,
  output logic               mem_rdata_valid_o,
  output logic               stallreq_o,
  output logic               bus_err_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          wr_q, wr_d;
  logic          req_q, req_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          timeout_c;

`ifdef DATA_SRAM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [DW-1:0] ABORT_RDATA = ERR_RDATA;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: restart on every entry to ADDR, count through ADDR and DATA.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == ADDR) && (state_q != ADDR)) begin
      cnt_d = '0;
    end else if ((state_q == ADDR) || (state_q == DATA)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam logic [DW-1:0] ABORT_RDATA = '0;

  assign timeout_c = 1'b0;
`endif

  // Next-state, request latch and result capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_req_i) begin
          addr_d  = ex_addr_i;
          wdata_d = ex_wdata_i;
          wstrb_d = ex_wen_i;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // data_ok cannot legally arrive here, so only addr_ok or the watchdog matter.
        if (timeout_c) begin
          rdata_d = ABORT_RDATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (sram.data_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // A completion on the watchdog's last cycle still counts as success.
        if (sram.data_data_ok) begin
          rdata_d = (|wstrb_q) ? '0 : sram.data_rdata;
          state_d = DONE;
        end else if (timeout_c) begin
          rdata_d = ABORT_RDATA;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d = err_q;
        if (!pipe_stall_i) begin
          err_d = 1'b0;
          if (ex_req_i) begin
            addr_d  = ex_addr_i;
            wdata_d = ex_wdata_i;
            wstrb_d = ex_wen_i;
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_d    = |wstrb_d;
    req_d   = (state_d == ADDR);
    valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wr_q    <= wr_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign sram.data_req   = req_q;
  assign sram.data_wr    = wr_q;
  assign sram.data_wstrb = wstrb_q;
  assign sram.data_addr  = addr_q;
  assign sram.data_wdata = wdata_q;

  assign mem_rdata_o       = rdata_q;
  assign mem_rdata_valid_o = valid_q;
  assign bus_err_o         = err_q;

  // Stall while a request waits in IDLE or an access is in flight; forced low in reset.
  assign stallreq_o = !rst && ((state_q == IDLE) ? ex_req_i : (state_q != DONE));

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl with hand-computed expectations.
module tb_data_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_req;
  logic [3:0]  ex_wen;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        stallreq;
  logic        bus_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  data_sram_if sram ();

`ifdef DATA_SRAM_TIMEOUT_EN
  data_sram_ctrl #(
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
`else
  data_sram_ctrl dut (
`endif
    .clk               (clk),
    .rst               (rst),
    .ex_req_i          (ex_req),
    .ex_wen_i          (ex_wen),
    .ex_addr_i         (ex_addr),
    .ex_wdata_i        (ex_wdata),
    .pipe_stall_i      (pipe_stall),
    .sram              (sram.master),
    .mem_rdata_o       (mem_rdata),
    .mem_rdata_valid_o (mem_rdata_valid),
    .stallreq_o        (stallreq),
    .bus_err_o         (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs for this cycle.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst                = 1'b1;
    ex_req             = 1'b0;
    ex_wen             = 4'b0000;
    ex_addr            = '0;
    ex_wdata           = '0;
    pipe_stall         = 1'b0;
    sram.data_addr_ok  = 1'b0;
    sram.data_data_ok  = 1'b0;
    sram.data_rdata    = '0;

    // Reset state
    step();
    settle();
    check("rst_req",      32'(sram.data_req), 32'd0);
    check("rst_valid",    32'(mem_rdata_valid), 32'd0);
    check("rst_stall",    32'(stallreq), 32'd0);
    check("rst_rdata",    mem_rdata, 32'd0);
    check("rst_err",      32'(bus_err), 32'd0);
    step();
    rst = 1'b0;

    // Load with zero wait states
    ex_req = 1'b1; ex_wen = 4'b0000; ex_addr = 32'h0000_0100; ex_wdata = 32'h5555_5555;
    settle();
    check("ld_c0_stall",  32'(stallreq), 32'd1);
    check("ld_c0_req",    32'(sram.data_req), 32'd0);
    step();
    ex_req = 1'b0; sram.data_addr_ok = 1'b1;
    settle();
    check("ld_c1_req",    32'(sram.data_req), 32'd1);
    check("ld_c1_stall",  32'(stallreq), 32'd1);
    check("ld_c1_addr",   sram.data_addr, 32'h0000_0100);
    check("ld_c1_wr",     32'(sram.data_wr), 32'd0);
    step();
    sram.data_addr_ok = 1'b0; sram.data_data_ok = 1'b1; sram.data_rdata = 32'h1234_5678;
    settle();
    check("ld_c2_req",    32'(sram.data_req), 32'd0);
    check("ld_c2_stall",  32'(stallreq), 32'd1);
    check("ld_c2_valid",  32'(mem_rdata_valid), 32'd0);
    step();
    sram.data_data_ok = 1'b0; sram.data_rdata = '0;
    settle();
    check("ld_c3_valid",  32'(mem_rdata_valid), 32'd1);
    check("ld_c3_rdata",  mem_rdata, 32'h1234_5678);
    check("ld_c3_stall",  32'(stallreq), 32'd0);
    check("ld_c3_err",    32'(bus_err), 32'd0);
    step();
    settle();
    check("ld_idle_valid", 32'(mem_rdata_valid), 32'd0);
    check("ld_idle_stall", 32'(stallreq), 32'd0);
    check("ld_idle_req",   32'(sram.data_req), 32'd0);

    // Store with wait states on both phases
    ex_req = 1'b1; ex_wen = 4'b0011; ex_addr = 32'h0000_0200; ex_wdata = 32'hAABB_CCDD;
    step();
    ex_req = 1'b0; ex_wen = 4'b0000; ex_addr = '0; ex_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      sram.data_addr_ok = (i == 3);
      settle();
      check("st_addr_req",   32'(sram.data_req), 32'd1);
      check("st_addr_wr",    32'(sram.data_wr), 32'd1);
      check("st_addr_wstrb", 32'(sram.data_wstrb), 32'h3);
      check("st_addr_addr",  sram.data_addr, 32'h0000_0200);
      check("st_addr_wdata", sram.data_wdata, 32'hAABB_CCDD);
      check("st_addr_stall", 32'(stallreq), 32'd1);
      step();
    end
    sram.data_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sram.data_data_ok = (i == 2);
      sram.data_rdata   = 32'hFFFF_FFFF;
      settle();
      check("st_data_req",   32'(sram.data_req), 32'd0);
      check("st_data_stall", 32'(stallreq), 32'd1);
      check("st_data_valid", 32'(mem_rdata_valid), 32'd0);
      step();
    end
    sram.data_data_ok = 1'b0; sram.data_rdata = '0;

    // In DONE with a new request and no downstream stall: back-to-back load
    ex_req = 1'b1; ex_wen = 4'b0000; ex_addr = 32'h0000_0300;
    settle();
    check("st_done_valid", 32'(mem_rdata_valid), 32'd1);
    check("st_done_rdata", mem_rdata, 32'd0);
    check("st_done_stall", 32'(stallreq), 32'd0);
    step();
    ex_req = 1'b0; ex_addr = '0; sram.data_addr_ok = 1'b1;
    settle();
    check("b2b_valid",     32'(mem_rdata_valid), 32'd0);
    check("b2b_req",       32'(sram.data_req), 32'd1);
    check("b2b_addr",      sram.data_addr, 32'h0000_0300);
    check("b2b_wr",        32'(sram.data_wr), 32'd0);
    check("b2b_stall",     32'(stallreq), 32'd1);
    step();
    sram.data_addr_ok = 1'b0; sram.data_data_ok = 1'b1; sram.data_rdata = 32'hCAFE_F00D;
    step();
    sram.data_data_ok = 1'b0; sram.data_rdata = '0;

    // Downstream stall holds the result for 4 cycles
    pipe_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_valid",  32'(mem_rdata_valid), 32'd1);
      check("hold_rdata",  mem_rdata, 32'hCAFE_F00D);
      check("hold_stall",  32'(stallreq), 32'd0);
      if (i == 3) pipe_stall = 1'b0;
      step();
    end
    settle();
    check("hold_exit_valid", 32'(mem_rdata_valid), 32'd0);
    check("hold_exit_stall", 32'(stallreq), 32'd0);
    check("hold_exit_rdata", mem_rdata, 32'hCAFE_F00D);

    // Asynchronous reset while in DATA
    ex_req = 1'b1; ex_addr = 32'h0000_0400;
    step();
    ex_req = 1'b0; ex_addr = '0; sram.data_addr_ok = 1'b1;
    step();
    sram.data_addr_ok = 1'b0;
    settle();
    check("rstmid_stall_pre", 32'(stallreq), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_stall",  32'(stallreq), 32'd0);
    check("rstmid_rdata",  mem_rdata, 32'd0);
    check("rstmid_addr",   sram.data_addr, 32'd0);
    check("rstmid_req",    32'(sram.data_req), 32'd0);
    step();
    rst = 1'b0;
    sram.data_data_ok = 1'b1; sram.data_rdata = 32'h1111_2222;
    step();
    sram.data_data_ok = 1'b0; sram.data_rdata = '0;
    settle();
    check("late_ok_valid", 32'(mem_rdata_valid), 32'd0);
    check("late_ok_rdata", mem_rdata, 32'd0);
    check("late_ok_stall", 32'(stallreq), 32'd0);
    check("late_ok_req",   32'(sram.data_req), 32'd0);

    // SRAM never accepts the address
    ex_req = 1'b1; ex_addr = 32'h0000_0500;
    step();
    ex_req = 1'b0; ex_addr = '0;
`ifdef DATA_SRAM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      settle();
      check("to_wait_valid", 32'(mem_rdata_valid), 32'd0);
      check("to_wait_stall", 32'(stallreq), 32'd1);
      check("to_wait_err",   32'(bus_err), 32'd0);
      step();
    end
    settle();
    check("to_done_valid", 32'(mem_rdata_valid), 32'd1);
    check("to_done_err",   32'(bus_err), 32'd1);
    check("to_done_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("to_done_req",   32'(sram.data_req), 32'd0);
    step();
    settle();
    check("to_exit_err",   32'(bus_err), 32'd0);
    check("to_exit_valid", 32'(mem_rdata_valid), 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      settle();
      check("hang_req",   32'(sram.data_req), 32'd1);
      check("hang_stall", 32'(stallreq), 32'd1);
      check("hang_err",   32'(bus_err), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("hang_rst_req", 32'(sram.data_req), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
